// File: rtl/r_capture_packetizer.sv
// Buffers captured AXI R beats in a record FIFO and emits each one as a
// two-beat AXI-Stream frame (header, then data). Also drives the tap throttle.
module r_capture_packetizer #(
    parameter int                             DATA_WIDTH        = 128,
    parameter int                             ID_WIDTH          = 32,
    parameter int                             STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0]   STREAM_TYPE       = '0,
    parameter int                             DEPTH             = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cap_valid,
    input  logic [DATA_WIDTH-1:0]   cap_data,
    input  logic [ID_WIDTH-1:0]     cap_id,
    input  logic [1:0]              cap_resp,
    input  logic                    cap_last,
    output logic                    can_forwardR,
    output logic                    m_tvalid,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic                    m_tlast,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    input  logic                    m_tready,
    output logic [15:0]             overflow_cnt,
    output logic [15:0]             seq_num
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = DATA_WIDTH + ID_WIDTH + 2 + 1 + 16;
    localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THROT_LVL = CNT_W'(DEPTH - 3);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t             state;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;
    logic [REC_W-1:0]   cap_rec;
    logic [REC_W-1:0]   head_rec;
    logic [REC_W-1:0]   next_rec;

    // Record layout, LSB first: seq[15:0], last, resp[1:0], id, data.
    function automatic logic [DATA_WIDTH-1:0] make_hdr(input logic [REC_W-1:0] rec);
        logic [DATA_WIDTH-1:0] h;
        h = '0;
        h[15:0]                              = rec[15:0];
        h[17:16]                             = rec[18:17];
        h[18]                                = rec[16];
        h[24 +: ID_WIDTH]                    = rec[19 +: ID_WIDTH];
        h[DATA_WIDTH-1 -: STREAM_TYPE_WIDTH] = STREAM_TYPE;
        return h;
    endfunction

    assign cap_rec  = {cap_data, cap_id, cap_resp, cap_last, seq_num};
    assign push     = cap_valid && (count < FULL_LVL);
    assign pop      = (state == S_DATA) && m_tready;
    assign head_rec = mem[rd_ptr];
    // After a pop at count==1 the next record is the one arriving this cycle.
    assign next_rec = (count > CNT_W'(1)) ? mem[rd_ptr + PTR_W'(1)] : cap_rec;

    assign can_forwardR = resetn && (count <= THROT_LVL);
    assign m_tkeep      = '1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cap_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= S_IDLE;
            m_tvalid     <= 1'b0;
            m_tlast      <= 1'b0;
            m_tdata      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            seq_num      <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (cap_valid) begin
                seq_num <= seq_num + 16'd1;
            end
            if (cap_valid && !push && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        m_tdata  <= make_hdr(head_rec);
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (m_tready) begin
                        m_tdata <= head_rec[REC_W-1 -: DATA_WIDTH];
                        m_tlast <= 1'b1;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_tready) begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                        if ((count > CNT_W'(1)) || push) begin
                            m_tdata <= make_hdr(next_rec);
                            m_tlast <= 1'b0;
                            state   <= S_HDR;
                        end else begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_capture_packetizer.sv
// Bench for r_capture_packetizer: directed table, corner-case sequences and
// random traffic checked against a queue-based model of the capture FIFO.
module tb_r_capture_packetizer;

    localparam int         DEPTH = 8;
    localparam logic [2:0] ST    = 3'b101;

    logic         clk = 1'b0;
    logic         resetn;
    logic         cap_valid;
    logic [127:0] cap_data;
    logic [31:0]  cap_id;
    logic [1:0]   cap_resp;
    logic         cap_last;
    logic         can_forwardR;
    logic         m_tvalid;
    logic [127:0] m_tdata;
    logic         m_tlast;
    logic [15:0]  m_tkeep;
    logic         m_tready;
    logic [15:0]  overflow_cnt;
    logic [15:0]  seq_num;

    r_capture_packetizer #(.STREAM_TYPE(ST), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .cap_valid(cap_valid), .cap_data(cap_data), .cap_id(cap_id),
        .cap_resp(cap_resp), .cap_last(cap_last),
        .can_forwardR(can_forwardR),
        .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .m_tready(m_tready),
        .overflow_cnt(overflow_cnt), .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [31:0]  id;
        logic [1:0]   resp;
        logic         last;
        logic [15:0]  seq;
    } rec_t;

    typedef struct {
        logic         cv;
        logic         rdy;
        logic [127:0] data;
        logic [31:0]  id;
        logic [1:0]   resp;
        logic         last;
        logic         ev;
        logic         el;
        logic [127:0] ed;
        logic         ecf;
    } vec_t;

    rec_t        mq[$];
    logic [15:0] m_seq;
    logic [15:0] m_ovf;
    logic        m_phase;
    int          stall;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_hdr(input rec_t r);
        logic [127:0] h;
        h          = '0;
        h[15:0]    = r.seq;
        h[17:16]   = r.resp;
        h[18]      = r.last;
        h[55:24]   = r.id;
        h[127:125] = ST;
        return h;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: drive inputs, score the handshake about to happen, advance the model.
    task automatic step(input logic cv, input logic [127:0] d, input logic [31:0] id,
                        input logic [1:0] rs, input logic lst, input logic rdy, input logic rn);
        logic         hs;
        logic         hold;
        logic [127:0] pd;
        logic         pl;
        rec_t         r;
        resetn    = rn;
        cap_valid = cv;
        cap_data  = d;
        cap_id    = id;
        cap_resp  = rs;
        cap_last  = lst;
        m_tready  = rdy;
        #1;
        hs   = m_tvalid && rdy;
        hold = m_tvalid && !rdy;
        pd   = m_tdata;
        pl   = m_tlast;
        if (!rn) begin
            mq.delete();
            m_seq   = '0;
            m_ovf   = '0;
            m_phase = 1'b0;
            hold    = 1'b0;
        end else begin
            if (hs) begin
                if (mq.size() == 0) begin
                    chk("spurious_beat", 1'b1, 1'b0);
                end else if (!m_phase) begin
                    chk("hdr_tdata", m_tdata, mk_hdr(mq[0]));
                    chk("hdr_tlast", m_tlast, 1'b0);
                end else begin
                    chk("data_tdata", m_tdata, mq[0].data);
                    chk("data_tlast", m_tlast, 1'b1);
                end
            end
            if (cv) begin
                if (mq.size() < DEPTH) begin
                    r = '{data: d, id: id, resp: rs, last: lst, seq: m_seq};
                    mq.push_back(r);
                end else if (m_ovf != 16'hFFFF) begin
                    m_ovf++;
                end
                m_seq++;
            end
            if (hs) begin
                if (m_phase && mq.size() > 0) void'(mq.pop_front());
                m_phase = !m_phase;
            end
        end
        @(posedge clk);
        #1;
        chk("seq_num", seq_num, m_seq);
        chk("overflow_cnt", overflow_cnt, m_ovf);
        chk("can_forwardR", can_forwardR, logic'(rn && (mq.size() <= DEPTH - 3)));
        if (hold) begin
            chk("hold_valid", m_tvalid, 1'b1);
            chk("hold_tdata", m_tdata, pd);
            chk("hold_tlast", m_tlast, pl);
        end
        if (mq.size() == 0 && !m_phase) chk("idle_valid", m_tvalid, 1'b0);
        if (mq.size() > 0 && !m_tvalid) stall++;
        else stall = 0;
        if (stall > 1) begin
            chk("output_stall", 1'b0, 1'b1);
            stall = 0;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, 2'd0, 1'b0, rdy, 1'b1);
    endtask

    task automatic cap(input logic rdy);
        step(1'b1, rnd128(), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rdy, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t         tv[4];
    logic [127:0] a5;
    logic [127:0] bp_data;

    initial begin
        m_seq   = '0;
        m_ovf   = '0;
        m_phase = 1'b0;
        stall   = 0;
        a5      = {16{8'hA5}};
        tv[0] = '{1'b1, 1'b1, a5, 32'h12, 2'd2, 1'b1, 1'b0, 1'b0, '0, 1'b1};
        tv[1] = '{1'b0, 1'b1, '0, '0, 2'd0, 1'b0, 1'b1, 1'b0,
                  {3'b101, 69'b0, 32'h12, 5'b0, 1'b1, 2'd2, 16'd0}, 1'b1};
        tv[2] = '{1'b0, 1'b1, '0, '0, 2'd0, 1'b0, 1'b1, 1'b1, a5, 1'b1};
        tv[3] = '{1'b0, 1'b1, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0, '0, 1'b1};

        // Reset state
        resetn = 1'b0;
        #1;
        chk("rst_cf_comb", can_forwardR, 1'b0);
        do_reset();
        chk("rst_tvalid", m_tvalid, 1'b0);
        chk("rst_tlast", m_tlast, 1'b0);
        chk("rst_tdata", m_tdata, '0);
        chk("rst_cf", can_forwardR, 1'b0);
        chk("tkeep", m_tkeep, 16'hFFFF);

        // Single beat, table-driven
        for (int i = 0; i < 4; i++) begin
            step(tv[i].cv, tv[i].data, tv[i].id, tv[i].resp, tv[i].last, tv[i].rdy, 1'b1);
            chk("tv_valid", m_tvalid, tv[i].ev);
            chk("tv_cf", can_forwardR, tv[i].ecf);
            if (tv[i].ev) begin
                chk("tv_tdata", m_tdata, tv[i].ed);
                chk("tv_tlast", m_tlast, tv[i].el);
            end
        end

        // Back-pressure in HDR
        bp_data = rnd128();
        step(1'b1, bp_data, 32'h55, 2'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        chk("bp_hdr_valid", m_tvalid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            chk("bp_hdr_seq", m_tdata[15:0], 16'd1);
            chk("bp_hdr_last", m_tlast, 1'b0);
        end
        idle(1'b1);
        chk("bp_data_valid", m_tvalid, 1'b1);
        chk("bp_data", m_tdata, bp_data);
        chk("bp_data_last", m_tlast, 1'b1);
        idle(1'b1);

        // Fill to overflow with the sink stalled, then drain
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            cap(1'b0);
            chk("fill_cf", can_forwardR, logic'(k <= 5));
        end
        chk("fill_ovf", overflow_cnt, 16'd2);
        for (int i = 0; i < 20; i++) idle(1'b1);
        chk("fill_seq", seq_num, 16'd10);
        cap(1'b0);
        idle(1'b0);
        chk("fill_next_seq", m_tdata[15:0], 16'd10);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Push and pop on the same edge at count 1
        do_reset();
        cap(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("pp_in_data", m_tlast, 1'b1);
        cap(1'b1);
        chk("pp_valid", m_tvalid, 1'b1);
        chk("pp_hdr_last", m_tlast, 1'b0);
        chk("pp_hdr_seq", m_tdata[15:0], 16'd1);
        chk("pp_cf", can_forwardR, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Reset during DATA, with further records queued behind it
        cap(1'b1);
        cap(1'b1);
        cap(1'b1);
        idle(1'b0);
        step(1'b0, '0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_valid", m_tvalid, 1'b0);
        chk("mid_rst_tlast", m_tlast, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("post_rst_idle", m_tvalid, 1'b0);
        cap(1'b0);
        idle(1'b0);
        chk("post_rst_hdr_valid", m_tvalid, 1'b1);
        chk("post_rst_hdr_seq", m_tdata[15:0], 16'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 1) cap(1'($urandom_range(0, 9) < 7));
            else idle(1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 20; i++) idle(1'b1);

        // Sequence wrap and overflow saturation
        do_reset();
        for (int i = 0; i < 65535; i++) cap(1'b0);
        chk("wrap_seq", seq_num, 16'hFFFF);
        for (int i = 0; i < 20; i++) idle(1'b1);
        cap(1'b0);
        cap(1'b0);
        idle(1'b0);
        chk("wrap_hdr_ffff", m_tdata[15:0], 16'hFFFF);
        idle(1'b1);
        idle(1'b1);
        chk("wrap_hdr_0000", m_tdata[15:0], 16'h0000);
        for (int i = 0; i < 6; i++) idle(1'b1);
        for (int i = 0; i < 18; i++) cap(1'b0);
        chk("ovf_saturate", overflow_cnt, 16'hFFFF);
        for (int i = 0; i < 20; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
